// File: rtl/key_event_queue_if.sv
// Keycode/frame inputs and queued-event outputs between the USB PIO
// and the ball motion stage.
interface key_event_queue_if #(
    parameter int KEY_W = 8,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [KEY_W-1:0] keycode_in;
    logic             frame_clk;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;

    modport master (
        output keycode_in,
        output frame_clk,
        input  key_out,
        input  key_valid,
        input  fifo_count,
        input  overflow
    );

    modport slave (
        input  keycode_in,
        input  frame_clk,
        output key_out,
        output key_valid,
        output fifo_count,
        output overflow
    );
endinterface

// File: rtl/key_event_queue.sv
// Turns raw keycodes into press events, queues them and releases
// one per rising edge of frame_clk.
module key_event_queue #(
    parameter int DEPTH         = 4,
    parameter int KEY_W         = 8,
    parameter bit FILTER_ARROWS = 1'b1
) (
    input logic               Clk,
    input logic               Reset,
    key_event_queue_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [KEY_W-1:0] ARROW_LO = KEY_W'(8'h4F);
    localparam logic [KEY_W-1:0] ARROW_HI = KEY_W'(8'h52);

    logic [KEY_W-1:0] kc_q;
    logic [KEY_W-1:0] kc_prev;
    logic             s1;
    logic             s2;
    logic             s3;

    logic [KEY_W-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    logic [KEY_W-1:0] key_r;
    logic             valid_r;
    logic             ovf_r;

    logic pass;
    logic press;
    logic tick;
    logic full;
    logic empty;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        pass  = 1'b1;
        if (FILTER_ARROWS)
            pass = (kc_q >= ARROW_LO) && (kc_q <= ARROW_HI);
        press = (kc_q != '0) && (kc_q != kc_prev) && pass;
        tick  = s2 & ~s3;
        full  = (count == FULL_CNT);
        empty = (count == '0);
        pop   = tick & ~empty;
        // A pop in the same cycle frees the slot, so a full queue
        // still accepts the press.
        push  = press & (~full | pop);
        drop  = press & full & ~pop;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            kc_q    <= '0;
            kc_prev <= '0;
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
        end else begin
            kc_q    <= bus.keycode_in;
            kc_prev <= kc_q;
            s1      <= bus.frame_clk;
            s2      <= s1;
            s3      <= s2;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset && push)
            mem[wr_ptr] <= kc_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            unique case (1'b1)
                push & ~pop: count <= count + CW'(1);
                pop & ~push: count <= count - CW'(1);
                default:     count <= count;
            endcase
        end
    end

    // Output only changes on a frame tick; held for the whole frame.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_r   <= '0;
            valid_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            if (drop)
                ovf_r <= 1'b1;
            if (tick) begin
                unique case (1'b1)
                    pop: begin
                        key_r   <= mem[rd_ptr];
                        valid_r <= 1'b1;
                    end
                    default: begin
                        key_r   <= '0;
                        valid_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.key_out    = key_r;
    assign bus.key_valid  = valid_r;
    assign bus.fifo_count = count;
    assign bus.overflow   = ovf_r;
endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: directed table, hand sequences and a
// randomized run against a queue-based reference model.
module tb_key_event_queue;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] kc;
    logic       fclk;

    always #5 clk = ~clk;

    key_event_queue_if #(.KEY_W(8), .DEPTH(4)) bus_a ();
    key_event_queue_if #(.KEY_W(8), .DEPTH(4)) bus_b ();

    assign bus_a.keycode_in = kc;
    assign bus_a.frame_clk  = fclk;
    assign bus_b.keycode_in = kc;
    assign bus_b.frame_clk  = fclk;

    key_event_queue #(.DEPTH(4), .KEY_W(8), .FILTER_ARROWS(1'b1)) dut_a (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus_a)
    );

    key_event_queue #(.DEPTH(4), .KEY_W(8), .FILTER_ARROWS(1'b0)) dut_b (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: input history plus a list of pending events.
    logic [7:0] k1, k2;
    logic       f1, f2, f3;
    logic [7:0] mq [2][4];
    int         msz [2];
    logic [7:0] mout [2];
    logic       mval [2];
    logic       movf [2];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        logic tk;
        logic pr;
        if (rst) begin
            k1 = 0; k2 = 0; f1 = 0; f2 = 0; f3 = 0;
            for (int i = 0; i < 2; i++) begin
                msz[i] = 0; mout[i] = 0; mval[i] = 0; movf[i] = 0;
            end
        end else begin
            tk = f2 && !f3;
            for (int i = 0; i < 2; i++) begin
                pr = (k1 != 0) && (k1 != k2) &&
                     (i == 1 || (k1 >= 8'h4F && k1 <= 8'h52));
                if (tk) begin
                    if (msz[i] > 0) begin
                        mout[i] = mq[i][0];
                        for (int j = 0; j < 3; j++) mq[i][j] = mq[i][j+1];
                        msz[i]--;
                        mval[i] = 1;
                    end else begin
                        mout[i] = 0;
                        mval[i] = 0;
                    end
                end
                if (pr) begin
                    if (msz[i] < 4) begin
                        mq[i][msz[i]] = k1;
                        msz[i]++;
                    end else begin
                        movf[i] = 1;
                    end
                end
            end
            k2 = k1; k1 = kc;
            f3 = f2; f2 = f1; f1 = fclk;
        end
    endtask

    task automatic model_check();
        check("mdl_a_key", bus_a.key_out, mout[0]);
        check("mdl_a_val", bus_a.key_valid, mval[0]);
        check("mdl_a_cnt", bus_a.fifo_count, msz[0]);
        check("mdl_a_ovf", bus_a.overflow, movf[0]);
        check("mdl_b_key", bus_b.key_out, mout[1]);
        check("mdl_b_val", bus_b.key_valid, mval[1]);
        check("mdl_b_cnt", bus_b.fifo_count, msz[1]);
        check("mdl_b_ovf", bus_b.overflow, movf[1]);
    endtask

    // Drive at negedge, let one posedge pass, compare at next negedge.
    task automatic cyc(input logic r, input logic [7:0] k, input logic f);
        rst = r; kc = k; fclk = f;
        @(posedge clk);
        model_step();
        @(negedge clk);
        model_check();
    endtask

    task automatic frame(input logic [7:0] k);
        cyc(0, k, 1); cyc(0, k, 1); cyc(0, k, 0); cyc(0, k, 0);
    endtask

    task automatic pk(input logic [7:0] k);
        cyc(0, k, 0); cyc(0, 8'h00, 0);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    endtask

    task automatic chk_a(input string nm, input logic [7:0] ek,
                         input logic ev, input int ec, input logic eo);
        check({nm, "_key"}, bus_a.key_out, ek);
        check({nm, "_val"}, bus_a.key_valid, ev);
        check({nm, "_cnt"}, bus_a.fifo_count, ec);
        check({nm, "_ovf"}, bus_a.overflow, eo);
    endtask

    typedef struct {
        logic       r;
        logic [7:0] k;
        logic       f;
        logic [7:0] ek;
        logic       ev;
        int         ec;
        logic       eo;
    } vec_t;

    vec_t tbl [40];
    int   nv = 0;

    task automatic add(input logic r, input logic [7:0] k, input logic f,
                       input logic [7:0] ek, input logic ev, input int ec,
                       input logic eo);
        tbl[nv] = '{r, k, f, ek, ev, ec, eo};
        nv++;
    endtask

    initial begin
        int peak;
        int fcnt;
        rst = 1; kc = 0; fclk = 0;
        k1 = 0; k2 = 0; f1 = 0; f2 = 0; f3 = 0;
        for (int i = 0; i < 2; i++) begin
            msz[i] = 0; mout[i] = 0; mval[i] = 0; movf[i] = 0;
        end

        // Overflow burst then five frames, one row per clock.
        add(1, 8'h00, 0, 8'h00, 0, 0, 0);
        add(0, 8'h4F, 0, 8'h00, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 1, 0);
        add(0, 8'h50, 0, 8'h00, 0, 1, 0);
        add(0, 8'h00, 0, 8'h00, 0, 2, 0);
        add(0, 8'h51, 0, 8'h00, 0, 2, 0);
        add(0, 8'h00, 0, 8'h00, 0, 3, 0);
        add(0, 8'h52, 0, 8'h00, 0, 3, 0);
        add(0, 8'h00, 0, 8'h00, 0, 4, 0);
        add(0, 8'h4F, 0, 8'h00, 0, 4, 0);
        add(0, 8'h00, 0, 8'h00, 0, 4, 1);
        add(0, 8'h00, 1, 8'h00, 0, 4, 1);
        add(0, 8'h00, 1, 8'h00, 0, 4, 1);
        add(0, 8'h00, 0, 8'h4F, 1, 3, 1);
        add(0, 8'h00, 0, 8'h4F, 1, 3, 1);
        add(0, 8'h00, 1, 8'h4F, 1, 3, 1);
        add(0, 8'h00, 1, 8'h4F, 1, 3, 1);
        add(0, 8'h00, 0, 8'h50, 1, 2, 1);
        add(0, 8'h00, 0, 8'h50, 1, 2, 1);
        add(0, 8'h00, 1, 8'h50, 1, 2, 1);
        add(0, 8'h00, 1, 8'h50, 1, 2, 1);
        add(0, 8'h00, 0, 8'h51, 1, 1, 1);
        add(0, 8'h00, 0, 8'h51, 1, 1, 1);
        add(0, 8'h00, 1, 8'h51, 1, 1, 1);
        add(0, 8'h00, 1, 8'h51, 1, 1, 1);
        add(0, 8'h00, 0, 8'h52, 1, 0, 1);
        add(0, 8'h00, 0, 8'h52, 1, 0, 1);
        add(0, 8'h00, 1, 8'h52, 1, 0, 1);
        add(0, 8'h00, 1, 8'h52, 1, 0, 1);
        add(0, 8'h00, 0, 8'h00, 0, 0, 1);
        add(0, 8'h00, 0, 8'h00, 0, 0, 1);

        @(negedge clk);

        cyc(1, 8'h52, 1);
        cyc(1, 8'h52, 0);
        chk_a("reset", 8'h00, 0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);

        peak = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc(0, 8'h52, 0);
            if (int'(bus_a.fifo_count) > peak) peak = bus_a.fifo_count;
        end
        check("hold_peak", peak, 1);
        frame(8'h52);
        chk_a("hold_f1", 8'h52, 1, 0, 0);
        frame(8'h52);
        chk_a("hold_f2", 8'h00, 0, 0, 0);
        frame(8'h52);
        chk_a("hold_f3", 8'h00, 0, 0, 0);

        for (int i = 0; i < nv; i++) begin
            cyc(tbl[i].r, tbl[i].k, tbl[i].f);
            chk_a($sformatf("tbl%0d", i), tbl[i].ek, tbl[i].ev,
                  tbl[i].ec, tbl[i].eo);
        end

        do_reset();
        cyc(0, 8'h04, 0); cyc(0, 8'h04, 0); cyc(0, 8'h04, 0);
        check("filt_a_cnt", bus_a.fifo_count, 0);
        check("filt_b_cnt", bus_b.fifo_count, 1);
        cyc(0, 8'h52, 0); cyc(0, 8'h52, 0);
        check("filt_a_cnt2", bus_a.fifo_count, 1);
        check("filt_b_cnt2", bus_b.fifo_count, 2);

        do_reset();
        pk(8'h4F); pk(8'h50); pk(8'h51); pk(8'h52);
        check("full_cnt", bus_a.fifo_count, 4);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h50, 1);
        cyc(0, 8'h00, 0);
        chk_a("pushpop", 8'h4F, 1, 4, 0);
        cyc(0, 8'h00, 0);
        frame(8'h00);
        chk_a("pushpop_next", 8'h50, 1, 3, 0);

        do_reset();
        cyc(0, 8'h00, 1);
        cyc(0, 8'h51, 1);
        cyc(0, 8'h00, 0);
        chk_a("nobypass", 8'h00, 0, 1, 0);
        cyc(0, 8'h00, 0);
        frame(8'h00);
        chk_a("nobypass_next", 8'h51, 1, 0, 0);
        pk(8'h4F); pk(8'h50); pk(8'h51);
        check("mid_cnt", bus_a.fifo_count, 3);
        cyc(0, 8'h00, 1);
        cyc(1, 8'h52, 1);
        chk_a("mid_reset", 8'h00, 0, 0, 0);
        cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);

        fcnt = 0;
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic [7:0] k;
            logic       f;
            int         sel;
            k = kc;
            f = fclk;
            if ($urandom_range(0, 3) == 0) begin
                sel = $urandom_range(0, 9);
                if (sel <= 2) k = 8'h00;
                else if (sel <= 6) k = 8'h4F + 8'(sel - 3);
                else if (sel == 7) k = 8'h04;
                else if (sel == 8) k = 8'($urandom);
            end
            if (fcnt == 0) begin
                f = ~fclk;
                fcnt = $urandom_range(3, 12);
            end else begin
                fcnt--;
            end
            r = ($urandom_range(0, 399) == 0);
            cyc(r, k, f);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
